// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the ADC scan sequencer.
//   ADC_BITS : width of the ADC controller result bus (B)
//   state_t  : sequencer FSM encoding (S_IDLE is the all-zero reset state)
//   clog2    : ceiling log2, used for the mux select and timer widths
package adc_scan_sequencer_pkg;

  localparam int ADC_BITS = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_ACCUM     = 3'd5,
    S_EMIT      = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_timeout_counter.sv
// Loadable down-counter used for both mux settling and datardy timeouts.
//   Clock, Reset : clock, async active-high reset (count -> 0)
//   load         : load load_value this cycle (takes priority over enable)
//   load_value   : value loaded; the counter expires load_value+1 cycles later
//   enable       : decrement while nonzero
//   expired      : count is zero
module adc_timeout_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans enabled analog mux channels, averages 2^AVG_LOG2 ADC conversions per
// channel and emits one result per channel.
//   Clock, Reset        : clock, async active-high reset
//   scan_start          : request a scan (dropped while busy)
//   continuous          : restart automatically at end of scan
//   chan_mask           : enabled channels, latched on scan acceptance
//   adc_datardy/adc_data: ADC controller ready level and result
//   adc_start           : one-cycle conversion request
//   mux_sel             : analog mux select
//   busy                : scan in progress
//   result_*            : one-cycle result strobe with channel/data/error
//   scan_done           : one-cycle end-of-scan strobe
//   timeout_sticky      : a conversion timed out since the last scan_start
//   dbg_state           : current FSM state
//
// ADC handshake: adc_start is a single-cycle request. The controller's
// adc_datardy may still be high from the previous conversion, so the sequencer
// first waits for it to go low, then for it to rise; adc_data is sampled on the
// first cycle adc_datardy is seen high. Each wait is bounded by TIMEOUT_CYCLES.
// All outputs are registered.
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CW            = clog2(NUM_CH)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                scan_start,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   chan_mask,
  input  logic                adc_datardy,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic                adc_start,
  output logic [CW-1:0]       mux_sel,
  output logic                busy,
  output logic                result_valid,
  output logic [CW-1:0]       result_chan,
  output logic [ADC_BITS-1:0] result_data,
  output logic                result_err,
  output logic                scan_done,
  output logic                timeout_sticky,
  output state_t              dbg_state
);

  localparam int TMAX  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW    = clog2(TMAX + 1);
  localparam int AW    = ADC_BITS + AVG_LOG2;
  localparam int NW    = AVG_LOG2 + 1;
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0] NUM_SAMPLES  = NW'(1 << AVG_LOG2);

  state_t state, state_n;

  logic [NUM_CH-1:0]   mask_q;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [NW-1:0]       cnt;
  logic [NW-1:0]       cnt_n;
  logic [ADC_BITS-1:0] sample;
  logic                err_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_en;
  logic          tmr_expired;

  logic          accept_start;
  logic          relatch;
  logic          capture;
  logic          timeout;
  logic [CW:0]   first_ch;
  logic [CW:0]   next_ch;

  // {hit, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CW:0] find_next(input logic [NUM_CH-1:0] m, input int from);
    logic [CW:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  assign first_ch  = find_next(chan_mask, 0);
  assign next_ch   = find_next(mask_q, int'(mux_sel) + 1);
  assign acc_sum   = acc + AW'(sample);
  assign cnt_n     = cnt + 1'b1;
  assign dbg_state = state;

  adc_timeout_counter #(.W(TW)) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (tmr_load),
    .load_value (tmr_load_val),
    .enable     (tmr_en),
    .expired    (tmr_expired)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    tmr_en       = 1'b0;
    accept_start = 1'b0;
    relatch      = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_start) begin
          accept_start = 1'b1;
          state_n      = first_ch[CW] ? S_SETTLE : S_DONE;
        end
      end
      S_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_n = S_START;
      end
      S_START: state_n = S_WAIT_LOW;
      S_WAIT_LOW: begin
        tmr_en = 1'b1;
        if (!adc_datardy) begin
          state_n = S_WAIT_HIGH;
        end else if (tmr_expired) begin
          timeout = 1'b1;
          state_n = S_ACCUM;
        end
      end
      S_WAIT_HIGH: begin
        tmr_en = 1'b1;
        if (adc_datardy) begin
          capture = 1'b1;
          state_n = S_ACCUM;
        end else if (tmr_expired) begin
          timeout = 1'b1;
          state_n = S_ACCUM;
        end
      end
      S_ACCUM: state_n = (cnt_n < NUM_SAMPLES) ? S_START : S_EMIT;
      S_EMIT:  state_n = next_ch[CW] ? S_SETTLE : S_DONE;
      S_DONE: begin
        if (continuous) begin
          relatch = 1'b1;
          state_n = first_ch[CW] ? S_SETTLE : S_DONE;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The shared timer restarts on entry to every timed state.
    tmr_load     = (state_n != state) &&
                   ((state_n == S_SETTLE) || (state_n == S_WAIT_LOW) || (state_n == S_WAIT_HIGH));
    tmr_load_val = (state_n == S_SETTLE) ? SETTLE_LOAD : TIMEOUT_LOAD;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      adc_start      <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      scan_done      <= 1'b0;
      mux_sel        <= '0;
      mask_q         <= '0;
      timeout_sticky <= 1'b0;
      sample         <= '0;
      err_q          <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      result_chan    <= '0;
      result_data    <= '0;
      result_err     <= 1'b0;
    end else begin
      // Strobes are decoded from the next state so they line up with it.
      adc_start    <= (state_n == S_START);
      busy         <= (state_n != S_IDLE);
      result_valid <= (state_n == S_EMIT);
      scan_done    <= (state_n == S_DONE);

      if (accept_start || relatch) begin
        mask_q <= chan_mask;
        if (first_ch[CW]) mux_sel <= first_ch[CW-1:0];
      end
      if (state == S_EMIT && next_ch[CW]) mux_sel <= next_ch[CW-1:0];

      if (accept_start)  timeout_sticky <= 1'b0;
      else if (timeout)  timeout_sticky <= 1'b1;

      if (capture) sample <= adc_data;
      if (timeout) begin
        sample <= '0;
        err_q  <= 1'b1;
      end

      if (state == S_ACCUM) begin
        acc <= acc_sum;
        cnt <= cnt_n;
        if (cnt_n >= NUM_SAMPLES) begin
          result_data <= ADC_BITS'(acc_sum >> AVG_LOG2);
          result_chan <= mux_sel;
          result_err  <= err_q;
        end
      end

      if (state == S_EMIT) begin
        acc   <= '0;
        cnt   <= '0;
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;
  import adc_scan_sequencer_pkg::*;

  // clock / reset
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic       scan_start  = 1'b0;
  logic       continuous  = 1'b0;
  logic [3:0] chan_mask   = 4'b0000;
  logic       adc_datardy = 1'b0;
  logic [5:0] adc_data    = 6'd0;
  logic       adc_start;
  logic [1:0] mux_sel;
  logic       busy;
  logic       result_valid;
  logic [1:0] result_chan;
  logic [5:0] result_data;
  logic       result_err;
  logic       scan_done;
  logic       timeout_sticky;
  state_t     dbg_state;

  adc_scan_sequencer #(
    .NUM_CH(4), .SETTLE_CYCLES(8), .AVG_LOG2(2), .TIMEOUT_CYCLES(255)
  ) dut (
    .Clock(Clock), .Reset(Reset), .scan_start(scan_start), .continuous(continuous),
    .chan_mask(chan_mask), .adc_datardy(adc_datardy), .adc_data(adc_data),
    .adc_start(adc_start), .mux_sel(mux_sel), .busy(busy), .result_valid(result_valid),
    .result_chan(result_chan), .result_data(result_data), .result_err(result_err),
    .scan_done(scan_done), .timeout_sticky(timeout_sticky), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ADC model stimulus tables (written only by the main initial block)
  logic [5:0] codes [4][4];
  int hang_ch = -1;
  int hang_k  = -1;

  // ADC model: datardy drops after a start and rises ~70 cycles later
  int         conv_cnt [4];
  int         rdy_timer = 0;
  bit         armed = 1'b0;
  logic [5:0] pend = 6'd0;
  bit         m_start;
  bit         m_busy;
  int         m_ch;
  int         m_k;
  always @(posedge Clock) begin
    m_start = adc_start;
    m_busy  = busy;
    m_ch    = int'(mux_sel);
    #1;
    if (!m_busy) begin
      for (int i = 0; i < 4; i++) conv_cnt[i] = 0;
    end
    if (m_start) begin
      adc_datardy = 1'b0;
      m_k = conv_cnt[m_ch] % 4;
      conv_cnt[m_ch] = conv_cnt[m_ch] + 1;
      if (m_ch == hang_ch && m_k == hang_k) begin
        armed = 1'b0;
      end else begin
        armed     = 1'b1;
        rdy_timer = 70;
        pend      = codes[m_ch][m_k];
      end
    end else if (armed) begin
      rdy_timer = rdy_timer - 1;
      if (rdy_timer == 0) begin
        adc_datardy = 1'b1;
        adc_data    = pend;
        armed       = 1'b0;
      end
    end
  end

  // monitor: records strobes and results on the falling edge
  int         start_cnt [4] = '{0, 0, 0, 0};
  int         done_cnt = 0;
  int         res_cnt  = 0;
  logic [8:0] got_arr [64];
  always @(negedge Clock) begin
    if (!Reset) begin
      if (adc_start) start_cnt[mux_sel] = start_cnt[mux_sel] + 1;
      if (scan_done) done_cnt = done_cnt + 1;
      if (result_valid && res_cnt < 64) begin
        got_arr[res_cnt] = {result_err, result_chan, result_data};
        res_cnt = res_cnt + 1;
      end
    end
  end

  // scoreboard: {err, chan, data}
  logic [8:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input logic [3:0] mask);
    @(negedge Clock);
    chan_mask  = mask;
    scan_start = 1'b1;
    @(negedge Clock);
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!scan_done && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(scan_done), 32'd1);
  endtask

  // compare results recorded since index 'base' against exp_q
  task automatic check_results(input string tag, input int base);
    int n;
    logic [8:0] e;
    n = exp_q.size();
    check({tag, "_result_count"}, 32'(res_cnt - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (base + i < res_cnt) check({tag, "_result"}, 32'(got_arr[base + i]), 32'(e));
    end
  endtask

  task automatic scan_1011(input string tag);
    int b_res, b_done;
    int b_st [4];
    for (int k = 0; k < 4; k++) begin
      codes[0][k] = 6'd10;
      codes[1][k] = 6'd63;
      codes[3][k] = 6'd0;
    end
    b_res  = res_cnt;
    b_done = done_cnt;
    for (int i = 0; i < 4; i++) b_st[i] = start_cnt[i];
    exp_q.push_back({1'b0, 2'd0, 6'd10});
    exp_q.push_back({1'b0, 2'd1, 6'd63});
    exp_q.push_back({1'b0, 2'd3, 6'd0});
    pulse_start(4'b1011);
    wait_done(tag, 3000);
    @(negedge Clock);
    #1;
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - b_done), 32'd1);
    check({tag, "_starts_ch0"}, 32'(start_cnt[0] - b_st[0]), 32'd4);
    check({tag, "_starts_ch1"}, 32'(start_cnt[1] - b_st[1]), 32'd4);
    check({tag, "_starts_ch2"}, 32'(start_cnt[2] - b_st[2]), 32'd0);
    check({tag, "_starts_ch3"}, 32'(start_cnt[3] - b_st[3]), 32'd4);
    check_results(tag, b_res);
  endtask

  initial begin
    int b_res, b_done, n;
    int b_st [4];

    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) codes[c][k] = 6'd0;

    // reset state
    repeat (3) @(negedge Clock);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_sticky", 32'(timeout_sticky), 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // three-channel scan
    scan_1011("mask1011");

    // averaging truncation: 5+6+6+6 = 23 -> 5
    codes[0][0] = 6'd5; codes[0][1] = 6'd6; codes[0][2] = 6'd6; codes[0][3] = 6'd6;
    b_res = res_cnt;
    exp_q.push_back({1'b0, 2'd0, 6'd5});
    pulse_start(4'b0001);
    wait_done("trunc", 2000);
    @(negedge Clock);
    #1;
    check_results("trunc", b_res);

    // timeout on ch1 second conversion: (8+12+16)>>2 = 9, err
    for (int k = 0; k < 4; k++) codes[0][k] = 6'd20;
    codes[1][0] = 6'd8; codes[1][1] = 6'd50; codes[1][2] = 6'd12; codes[1][3] = 6'd16;
    hang_ch = 1;
    hang_k  = 1;
    b_res = res_cnt;
    b_st[1] = start_cnt[1];
    exp_q.push_back({1'b0, 2'd0, 6'd20});
    exp_q.push_back({1'b1, 2'd1, 6'd9});
    pulse_start(4'b0011);
    wait_done("timeout", 4000);
    @(negedge Clock);
    #1;
    check("timeout_sticky", 32'(timeout_sticky), 32'd1);
    check("timeout_starts_ch1", 32'(start_cnt[1] - b_st[1]), 32'd4);
    check("timeout_busy_low", 32'(busy), 32'd0);
    check_results("timeout", b_res);
    hang_ch = -1;
    hang_k  = -1;

    // zero mask: DONE right after acceptance, no conversions
    b_res  = res_cnt;
    b_done = done_cnt;
    for (int i = 0; i < 4; i++) b_st[i] = start_cnt[i];
    pulse_start(4'b0000);
    check("zero_scan_done", 32'(scan_done), 32'd1);
    check("zero_busy_in_done", 32'(busy), 32'd1);
    check("zero_sticky_cleared", 32'(timeout_sticky), 32'd0);
    @(negedge Clock);
    check("zero_busy_low", 32'(busy), 32'd0);
    check("zero_done_low", 32'(scan_done), 32'd0);
    #1;
    check("zero_no_starts", 32'(start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3]
                               - b_st[0] - b_st[1] - b_st[2] - b_st[3]), 32'd0);
    check("zero_no_results", 32'(res_cnt - b_res), 32'd0);
    check("zero_done_count", 32'(done_cnt - b_done), 32'd1);

    // continuous mode with a mid-scan mask change
    for (int k = 0; k < 4; k++) begin
      codes[0][k] = 6'd33;
      codes[2][k] = 6'd40;
    end
    b_res  = res_cnt;
    b_done = done_cnt;
    for (int i = 0; i < 4; i++) b_st[i] = start_cnt[i];
    continuous = 1'b1;
    pulse_start(4'b0001);
    repeat (20) @(negedge Clock);
    chan_mask = 4'b0100;
    exp_q.push_back({1'b0, 2'd0, 6'd33});
    wait_done("cont1", 2000);
    @(negedge Clock);
    #1;
    check("cont1_still_busy", 32'(busy), 32'd1);
    check_results("cont1", b_res);
    repeat (5) @(negedge Clock);
    scan_start = 1'b1;
    @(negedge Clock);
    scan_start = 1'b0;
    continuous = 1'b0;
    exp_q.push_back({1'b0, 2'd2, 6'd40});
    wait_done("cont2", 2000);
    @(negedge Clock);
    #1;
    check("cont2_busy_low", 32'(busy), 32'd0);
    check("cont_done_count", 32'(done_cnt - b_done), 32'd2);
    check("cont_starts_ch0", 32'(start_cnt[0] - b_st[0]), 32'd4);
    check("cont_starts_ch2", 32'(start_cnt[2] - b_st[2]), 32'd4);
    check_results("cont2", b_res + 1);

    // asynchronous reset in the middle of WAIT_HIGH
    for (int k = 0; k < 4; k++) codes[0][k] = 6'd10;
    pulse_start(4'b1011);
    n = 0;
    while (dbg_state !== S_WAIT_HIGH && n < 200) begin
      @(negedge Clock);
      n++;
    end
    check("rst2_reached_wait_high", 32'(dbg_state), 32'(S_WAIT_HIGH));
    repeat (10) @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_adc_start", 32'(adc_start), 32'd0);
    check("rst2_result_valid", 32'(result_valid), 32'd0);
    check("rst2_scan_done", 32'(scan_done), 32'd0);
    check("rst2_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    scan_1011("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
